// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pkg
// Purpose  : Shared definitions for the dual-issue IF/ID pipeline register
//            and its control sequencer.
//            - st_t          : sequencer state encoding (RUN / FLUSH)
//            - FLUSH_CYCLES_DEF : default flush window length
//            - SLOT1 / SLOT2 : slot indices used by the sequencer and decoder
// Revision : 1.0 - initial release
// ============================================================================
package if_id_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } st_t;

  localparam int FLUSH_CYCLES_DEF = 2;

  localparam int SLOT1 = 0;
  localparam int SLOT2 = 1;

endpackage : if_id_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that increments by one per cycle with inc=1 and
//            holds at all-ones once saturated.
// Ports    : clk   - rising-edge clock
//            reset - synchronous active-high reset, clears the count
//            inc   - count this cycle
//            count - current count value (CNT_W bits)
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/if_id_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_id_ctrl
// Purpose  : Per-cycle sequencer for the dual-issue IF/ID pipeline register.
//            Generates stall / flush / loop controls for the register and a
//            fetch-hold for the fetch stage. Owns the multi-cycle flush window
//            after a redirect and the partial-dispatch replay (I1 taken, I2
//            re-presented through the loop path).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            i1v, i2v            - slot valids held in the IF/ID register
//            dec_take[1:0]       - decoder consumed slot 1 / slot 2
//            backend_full        - dispatch cannot accept this cycle
//            redirect            - single-cycle branch redirect pulse
//            pr_stall, pr_flush, pr_loop - IF/ID register controls
//            fetch_hold          - freeze fetch PC and outputs
//            flush_busy          - flush window active
//            stall_count, flush_count, loop_count - performance counters
// Config   : PERF_CNT_EN - when defined, the three counters are implemented
//            as saturating counters; otherwise they are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_ctrl
  import if_id_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i1v,
  input  logic             i2v,
  input  logic [1:0]       dec_take,
  input  logic             backend_full,
  input  logic             redirect,
  output logic             pr_stall,
  output logic             pr_flush,
  output logic             pr_loop,
  output logic             fetch_hold,
  output logic             flush_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] loop_count
);

  localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  st_t        r_st;
  logic [3:0] r_fcnt;

  logic w_t1, w_t2, w_l1, w_l2;
  logic w_stall, w_flush, w_loop, w_hold, w_busy;

  // The decoder consumes in order: slot 2 only counts as taken when slot 1
  // was taken too, or slot 1 holds nothing.
  assign w_t1 = dec_take[SLOT1] & i1v;
  assign w_t2 = dec_take[SLOT2] & i2v & (w_t1 | ~i1v);
  assign w_l1 = i1v & ~w_t1;
  assign w_l2 = i2v & ~w_t2;

  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    w_loop  = 1'b0;
    w_hold  = 1'b0;
    w_busy  = 1'b0;
    if (reset) begin
      // everything held low during reset
    end else if (redirect) begin
      w_flush = 1'b1;
    end else if (r_st == FLUSH) begin
      w_flush = 1'b1;
      w_busy  = 1'b1;
    end else if (backend_full) begin
      // back-pressure stalls even an empty register
      w_stall = 1'b1;
      w_hold  = 1'b1;
    end else if (!w_l1 && !w_l2) begin
      // all consumed or empty: register loads fresh fetch
    end else if (w_t1 && w_l2) begin
      // partial dispatch: decoder re-presents I2 in slot 1 via the loop path
      w_loop = 1'b1;
      w_hold = 1'b1;
    end else begin
      w_stall = 1'b1;
      w_hold  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st   <= RUN;
      r_fcnt <= 4'd0;
    end else if (redirect) begin
      // a redirect inside the window restarts it
      if (FLUSH_CYCLES > 1) begin
        r_st   <= FLUSH;
        r_fcnt <= c_FLUSH_LOAD;
      end
    end else if (r_st == FLUSH) begin
      r_fcnt <= r_fcnt - 4'd1;
      if (r_fcnt == 4'd1) begin
        r_st <= RUN;
      end
    end
  end

  assign pr_stall   = w_stall;
  assign pr_flush   = w_flush;
  assign pr_loop    = w_loop;
  assign fetch_hold = w_hold;
  assign flush_busy = w_busy;

`ifdef PERF_CNT_EN
  logic w_redirect_acc;
  assign w_redirect_acc = redirect & ~reset;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_redirect_acc),
    .count (flush_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_loop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_loop),
    .count (loop_count)
  );
`else
  assign stall_count = '0;
  assign flush_count = '0;
  assign loop_count  = '0;
`endif

  a_ctrl_exclusive : assert property (@(posedge clk)
    $onehot0({pr_stall, pr_flush, pr_loop}));

endmodule : if_id_ctrl
`default_nettype wire

// File: tb/tb_if_id_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_ctrl
// Purpose  : Self-checking bench for if_id_ctrl (FLUSH_CYCLES=3, CNT_W=4).
//            Expected outputs come from an independent behavioural model and
//            travel through a scoreboard queue to the comparison point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_ctrl;

  localparam int FC = 3;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          i1v, i2v;
  logic [1:0]    dec_take;
  logic          backend_full;
  logic          redirect;
  logic          pr_stall, pr_flush, pr_loop, fetch_hold, flush_busy;
  logic [CW-1:0] stall_count, flush_count, loop_count;

  if_id_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i1v          (i1v),
    .i2v          (i2v),
    .dec_take     (dec_take),
    .backend_full (backend_full),
    .redirect     (redirect),
    .pr_stall     (pr_stall),
    .pr_flush     (pr_flush),
    .pr_loop      (pr_loop),
    .fetch_hold   (fetch_hold),
    .flush_busy   (flush_busy),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .loop_count   (loop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          stall;
    logic          flush;
    logic          loop_;
    logic          hold;
    logic          busy;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic [CW-1:0] lc;
  } exp_t;

  exp_t q_exp[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int     m_left = 0;   // flush cycles still owed after the current one
  int     m_sc = 0, m_fc = 0, m_lc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  // One cycle: drive inputs, predict, compare, then advance the model.
  task automatic step(input string tag, input bit rst, input bit a1, input bit a2,
                      input bit [1:0] tk, input bit bf, input bit rd);
    exp_t e, got;
    bit t1, t2, l1, l2;
    @(negedge clk);
    reset = rst; i1v = a1; i2v = a2; dec_take = tk; backend_full = bf; redirect = rd;

    t1 = tk[0] && a1;
    t2 = tk[1] && a2 && (t1 || !a1);
    l1 = a1 && !t1;
    l2 = a2 && !t2;
    e = '0;
    if (rst) begin
    end else if (rd) e.flush = 1'b1;
    else if (m_left > 0) begin e.flush = 1'b1; e.busy = 1'b1; end
    else if (bf) begin e.stall = 1'b1; e.hold = 1'b1; end
    else if (!l1 && !l2) begin end
    else if (t1 && l2) begin e.loop_ = 1'b1; e.hold = 1'b1; end
    else begin e.stall = 1'b1; e.hold = 1'b1; end
`ifdef PERF_CNT_EN
    e.sc = CW'(m_sc); e.fc = CW'(m_fc); e.lc = CW'(m_lc);
`endif
    q_exp.push_back(e);

    #1;
    got = q_exp.pop_front();
    chk({tag, ".stall"}, {31'd0, pr_stall},   {31'd0, got.stall});
    chk({tag, ".flush"}, {31'd0, pr_flush},   {31'd0, got.flush});
    chk({tag, ".loop"},  {31'd0, pr_loop},    {31'd0, got.loop_});
    chk({tag, ".hold"},  {31'd0, fetch_hold}, {31'd0, got.hold});
    chk({tag, ".busy"},  {31'd0, flush_busy}, {31'd0, got.busy});
    chk({tag, ".scnt"},  32'(stall_count),    32'(got.sc));
    chk({tag, ".fcnt"},  32'(flush_count),    32'(got.fc));
    chk({tag, ".lcnt"},  32'(loop_count),     32'(got.lc));

    @(posedge clk);
    if (rst) begin
      m_left = 0; m_sc = 0; m_fc = 0; m_lc = 0;
    end else begin
      if (e.stall) m_sc = sat_inc(m_sc);
      if (e.loop_) m_lc = sat_inc(m_lc);
      if (rd) m_fc = sat_inc(m_fc);
      if (rd) m_left = FC - 1;
      else if (m_left > 0) m_left = m_left - 1;
    end
  endtask

  initial begin
    reset = 1'b1; i1v = 1'b0; i2v = 1'b0; dec_take = 2'b00;
    backend_full = 1'b0; redirect = 1'b0;

    // reset with conflicting inputs active
    step("rst0", 1, 1, 1, 2'b11, 1, 1);
    step("rst1", 1, 1, 1, 2'b11, 1, 1);
    step("idle", 0, 0, 0, 2'b00, 0, 0);

    // dual dispatch
    step("dual", 0, 1, 1, 2'b11, 0, 0);
    // partial dispatch then the replayed I2 consumed
    step("part", 0, 1, 1, 2'b01, 0, 0);
    step("replay", 0, 1, 0, 2'b01, 0, 0);
    // out-of-order take is ignored
    step("ooo", 0, 1, 1, 2'b10, 0, 0);
    step("notake", 0, 1, 1, 2'b00, 0, 0);
    step("i1only_nt", 0, 1, 0, 2'b00, 0, 0);
    step("i2only_tk", 0, 0, 1, 2'b10, 0, 0);
    step("i2only_nt", 0, 0, 1, 2'b00, 0, 0);
    // empty register with and without back-pressure
    step("empty", 0, 0, 0, 2'b00, 0, 0);
    step("empty_bf", 0, 0, 0, 2'b00, 1, 0);
    step("full_bf", 0, 1, 1, 2'b11, 1, 0);

    // single redirect: three flush cycles
    step("rd1_c1", 0, 1, 1, 2'b11, 0, 1);
    step("rd1_c2", 0, 1, 1, 2'b11, 0, 0);
    step("rd1_c3", 0, 1, 1, 2'b11, 0, 0);
    step("rd1_end", 0, 1, 1, 2'b01, 0, 0);

    // second redirect on cycle 2 extends the window to cycle 4
    step("rd2_c1", 0, 1, 1, 2'b01, 0, 1);
    step("rd2_c2", 0, 1, 1, 2'b01, 0, 1);
    step("rd2_c3", 0, 1, 1, 2'b01, 0, 0);
    step("rd2_c4", 0, 1, 1, 2'b01, 0, 0);
    step("rd2_end", 0, 1, 1, 2'b01, 0, 0);

    // back-pressure interrupted by a redirect
    step("bp_a", 0, 1, 1, 2'b00, 1, 0);
    step("bp_b", 0, 1, 1, 2'b00, 1, 0);
    step("bp_rd", 0, 1, 1, 2'b00, 1, 1);
    step("bp_f2", 0, 1, 1, 2'b00, 1, 0);
    step("bp_f3", 0, 1, 1, 2'b00, 1, 0);
    step("bp_res", 0, 1, 1, 2'b00, 1, 0);

    // long stall run to reach counter saturation
    for (int i = 0; i < 20; i++) step("sat", 0, 1, 0, 2'b00, 1, 0);
    for (int i = 0; i < 18; i++) step("satloop", 0, 1, 1, 2'b01, 0, 0);

    // reset mid-run clears state and counters
    step("rd_pre", 0, 1, 1, 2'b11, 0, 1);
    step("rst_mid", 1, 1, 1, 2'b11, 0, 0);
    step("post_rst", 0, 1, 1, 2'b11, 0, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step("rnd", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 11) == 0));
    end
    step("final", 0, 0, 0, 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_if_id_ctrl
`default_nettype wire

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
Per-cycle sequencer for the dual-issue IF/ID pipeline register. Each cycle it generates the register's stall, flush and loop controls and a fetch-hold to the fetch stage. Inputs are the slot-valid flags held in the register, the decoder/dispatch consumption report, backend back-pressure and branch redirects. It owns the multi-cycle flush window after a redirect, and the partial-dispatch replay: I1 taken, I2 re-presented through the loop path.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles pr_flush is asserted per redirect (legal range 1..15)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i1v  in  1  slot-1 valid currently held in the IF/ID register
i2v  in  1  slot-2 valid currently held in the IF/ID register
dec_take  in  2  bit0/bit1: decoder consumed slot 1/slot 2 this cycle
backend_full  in  1  dispatch cannot accept anything this cycle
redirect  in  1  branch mispredict / PC redirect from execute, single-cycle pulse
pr_stall  out  1  to IF/ID stall
pr_flush  out  1  to IF/ID flush
pr_loop  out  1  to IF/ID loop select (load decoder-supplied leftover)
fetch_hold  out  1  freeze fetch PC and fetch outputs
flush_busy  out  1  flush window active (state FLUSH)
stall_count  out  CNT_W  cycles with pr_stall=1 (PERF_CNT_EN only, else tied 0)
flush_count  out  CNT_W  redirects accepted (PERF_CNT_EN only, else tied 0)
loop_count  out  CNT_W  cycles with pr_loop=1 (PERF_CNT_EN only, else tied 0)

Behaviour:
- Registered state: st in {RUN, FLUSH}, 4-bit flush counter fcnt. Control outputs are combinational from st and the inputs, with zero latency, so they act on the same edge.
- While reset=1: st<=RUN, fcnt<=0, counters<=0; all outputs driven 0.
- Effective take: t1 = dec_take[0] & i1v. t2 = dec_take[1] & i2v & (t1 | ~i1v). The decoder consumes strictly in order; an out-of-order take of slot 2 is ignored.
- Leftover: l1 = i1v & ~t1, l2 = i2v & ~t2.
- Priority each cycle, highest first:
  1. redirect=1: pr_flush=1, all other outputs 0. If FLUSH_CYCLES>1: st<=FLUSH, fcnt<=FLUSH_CYCLES-1. Otherwise st stays RUN.
  2. st==FLUSH: pr_flush=1, flush_busy=1, stall/loop/hold 0. fcnt<=fcnt-1; when fcnt==1, st<=RUN. A redirect in this state reloads fcnt (rule 1 wins).
  3. backend_full=1: pr_stall=1, fetch_hold=1.
  4. l1=0 and l2=0 (all consumed or register empty): all outputs 0; register loads fresh fetch.
  5. t1=1 and l2=1 (partial): pr_loop=1, fetch_hold=1, pr_stall=0. The decoder supplies I2 in slot 1 with slot 2 invalid.
  6. Otherwise (no progress, leftover present): pr_stall=1, fetch_hold=1.
- pr_stall, pr_flush and pr_loop are mutually exclusive in every cycle (assertion).
- flush_busy=1 only in state FLUSH.
- Empty register (i1v=i2v=0) with backend_full=1 still stalls; rule 3 precedes rule 4.

Optional Feature:
PERF_CNT_EN: when defined, stall_count, flush_count and loop_count increment by 1 per qualifying cycle. They saturate at all-ones and clear on reset. flush_count counts each redirect pulse, including one during FLUSH. When not defined, the three ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package if_id_pkg holds: the st enum (RUN=1'b0, FLUSH=1'b1), the default FLUSH_CYCLES constant, and the slot-index constants SLOT1=0 and SLOT2=1 used by both this block and the decoder.
- No sub-module needed.
- A small saturating counter, sat_counter (CNT_W, inc, reset), is instantiated three times under PERF_CNT_EN.

Test Plan:
- Reset sequence: reset=1 for 2 cycles with redirect=1 and backend_full=1 -> all outputs 0, then st=RUN and counters 0 after release.
- Full dual dispatch: i1v=i2v=1, dec_take=2'b11, backend_full=0 -> pr_stall=pr_flush=pr_loop=fetch_hold=0.
- Partial dispatch: i1v=i2v=1, dec_take=2'b01 -> pr_loop=1 and fetch_hold=1. Next cycle i1v=1, i2v=0, dec_take=2'b01 -> all 0. loop_count=1.
- Out-of-order take: i1v=i2v=1, dec_take=2'b10 -> t2 suppressed, so pr_stall=1, fetch_hold=1, pr_loop=0.
- Redirect, FLUSH_CYCLES=3: redirect pulse -> pr_flush=1 for exactly 3 cycles, flush_busy=1 on cycles 2-3. A second redirect on cycle 2 extends flush to cycle 4. flush_count=2.
- Backpressure vs flush: backend_full=1 held; a redirect mid-stall -> pr_flush wins (pr_stall=0) for FLUSH_CYCLES cycles, then pr_stall=1 resumes. stall_count excludes the flush cycles.
